memory_scan_arbiter: RTL
========================

Name: memory_scan_arbiter

Overview:
- Shares one single-port, 1-cycle-latency memory read port between NUM_PORTS scanner-style requesters.
- Each requester presents a request and an address. The arbiter grants one requester per cycle using round-robin with bounded bursts, drives the memory port, and returns the read data with a per-port valid one cycle later.
- Sits between the memory-scanning units of a unit instance and the instance's local memory.

Parameters:
- DATA_W, 32, memory word width.
- ADDR_W, 10, memory address width.
- NUM_PORTS, 4, number of requesters; legal range 2..8.
- BURST_MAX, 4, maximum consecutive grants to one port while others are waiting; legal range 1..15.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; asynchronous, active-high.
- clear_i  input  1  synchronous clear of arbitration state.
- req_i  input  NUM_PORTS  per-port read request; held until granted.
- addr_i  input  NUM_PORTS*ADDR_W  per-port address; port k occupies bits [k*ADDR_W +: ADDR_W].
- gnt_o  output  NUM_PORTS  one-hot grant, same cycle as the accepted request.
- rvalid_o  output  NUM_PORTS  one-hot; read data for port k is valid this cycle.
- rdata_o  output  DATA_W  read data, broadcast to all ports; qualify with rvalid_o.
- mem_addr_o  output  ADDR_W  memory address.
- mem_en_o  output  1  memory read enable.
- mem_data_i  input  DATA_W  memory read data, valid the cycle after mem_en_o.
- busy_o  output  1  high if any req_i is high or any rvalid_o is high.

Behaviour:
- Reset (rst_i=1):
  - Priority pointer = 0, burst counter = 0, last-grant register = 0, rvalid_o = 0.
  - gnt_o = 0, mem_en_o = 0, mem_addr_o = 0; rst_i masks these combinationally.
- Grant is combinational:
  - gnt_o[k] = 1 for the first requesting port at or after the pointer, in cyclic order.
  - gnt_o = 0 when req_i = 0 or clear_i = 1.
- Memory drive:
  - mem_en_o = |gnt_o.
  - mem_addr_o = address of the granted port.
  - mem_addr_o = 0 when there is no grant.
- Handshake:
  - A request is consumed in the cycle where req_i[k] and gnt_o[k] are both high.
  - The requester must hold req_i and addr_i stable until granted.
  - Deasserting req_i before a grant is legal; the request is dropped.
- Read latency is exactly 1:
  - rvalid_o is a register loaded with gnt_o.
  - rdata_o = mem_data_i, passed through combinationally.
- Burst and pointer update (registered, only when a grant occurs):
  - If the granted port equals the previous grant and the burst counter + 1 < BURST_MAX: pointer stays on that port, counter increments.
  - Otherwise: pointer = granted+1 modulo NUM_PORTS, counter resets to 0 (a new burst starts with counter 0).
  - A burst continues only while the same port requests in consecutive cycles.
- Idle cycle (no grant):
  - Pointer holds, counter resets to 0, last-grant register is cleared.
- Fairness:
  - Any continuously requesting port is granted within (NUM_PORTS-1)*BURST_MAX cycles.
- Single requester: granted every cycle; rotation is harmless.
- clear_i (synchronous, overrides everything except rst_i):
  - Pointer = 0, counter = 0, rvalid_o = 0 next cycle.
  - No grant in the clear cycle; a read already issued the cycle before is discarded (rvalid suppressed).
- Async reset mid-burst: all state returns to reset values immediately; outstanding read is discarded.
- Pointer arithmetic: width = clog2(NUM_PORTS); wrap explicitly at NUM_PORTS-1 → 0 for non-power-of-2 values.

Decomposition:
- Shared package:
  - ptr width localparam (clog2 NUM_PORTS).
  - counter width localparam (clog2 BURST_MAX+1).
  - Parameter range checks.
- One sub-module: rr_priority_select (NUM_PORTS). Combinational rotate-priority-encode: inputs request vector and pointer; outputs one-hot grant and grant index.
- Top holds pointer, burst counter, last-grant register, rvalid register and the address mux.

Test Plan:
- Reset then idle, req_i=0:
  - gnt_o=0, mem_en_o=0, rvalid_o=0, busy_o=0.
  - Assert rst_i mid-sim: outputs clear within the same cycle, without waiting for a clock edge.
- Single port 2, addr 0x010, then 0x014, 0x018 on consecutive cycles:
  - gnt_o=0100 each cycle; mem_addr_o follows.
  - rvalid_o=0100 one cycle later, rdata_o equal to the memory model's word.
- NUM_PORTS=4, BURST_MAX=4, all four ports request continuously:
  - Grant sequence is port 0 ×4, port 1 ×4, port 2 ×4, port 3 ×4, then port 0 again.
  - No port is starved longer than 12 cycles.
- BURST_MAX=1, ports 1 and 3 request:
  - Grants alternate 1,3,1,3.
  - Drop port 3 mid-sequence: port 1 is granted every cycle.
- clear_i pulse in the cycle after a grant to port 0:
  - rvalid_o stays 0 next cycle.
  - Pointer restarts at 0; the next grant with all ports requesting goes to port 0.
- Request withdrawn before grant: port 2 asserts for 1 cycle while port 0 holds the burst.
  - Port 2 is never granted; no spurious rvalid_o[2].

Source files
------------

// File: rtl/memory_scan_arbiter_pkg.sv
// Shared sizing helpers and parameter legality for the memory scan arbiter.
package memory_scan_arbiter_pkg;

  localparam int MIN_PORTS = 2;
  localparam int MAX_PORTS = 8;
  localparam int MAX_BURST = 15;

  // Pointer width; never zero so a 2-port build still has a 1-bit pointer.
  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int b);
    return (b <= 1) ? 1 : $clog2(b + 1);
  endfunction

  function automatic bit params_ok(input int n, input int b);
    return (n >= MIN_PORTS) && (n <= MAX_PORTS) && (b >= 1) && (b <= MAX_BURST);
  endfunction

endpackage

// File: rtl/memory_scan_arbiter_rr_priority_select.sv
// Rotating priority encoder: first requester at or after the pointer, cyclically.
module rr_priority_select
  import memory_scan_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PTR_W     = ptr_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [PTR_W-1:0]     i_ptr,
  output logic [NUM_PORTS-1:0] o_gnt,
  output logic [PTR_W-1:0]     o_idx,
  output logic                 o_vld
);

  always_comb begin
    int j;
    j     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      j = int'(i_ptr) + i;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (!o_vld && i_req[j]) begin
        o_vld    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/memory_scan_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one 1-cycle-latency memory read
// port between NUM_PORTS scanners; read data returns with a per-port valid.
module memory_scan_arbiter
  import memory_scan_arbiter_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int NUM_PORTS = 4,
  parameter int BURST_MAX = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic [NUM_PORTS-1:0]        req_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr_i,
  output logic [NUM_PORTS-1:0]        gnt_o,
  output logic [NUM_PORTS-1:0]        rvalid_o,
  output logic [DATA_W-1:0]           rdata_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic                        mem_en_o,
  input  logic [DATA_W-1:0]           mem_data_i,
  output logic                        busy_o
);

  localparam int PTR_W = ptr_w(NUM_PORTS);
  localparam int CNT_W = cnt_w(BURST_MAX);

  if (!params_ok(NUM_PORTS, BURST_MAX)) begin : g_param_check
    $error("memory_scan_arbiter: NUM_PORTS must be 2..8 and BURST_MAX 1..15");
  end

  logic [PTR_W-1:0]     r_ptr;
  logic [CNT_W-1:0]     r_cnt;
  logic [NUM_PORTS-1:0] r_last;
  logic [NUM_PORTS-1:0] r_rvalid;

  logic [NUM_PORTS-1:0] w_req;
  logic [NUM_PORTS-1:0] w_gnt;
  logic [PTR_W-1:0]     w_idx;
  logic                 w_vld;
  logic [ADDR_W-1:0]    w_addr;
  logic                 w_cont;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 w_burst_more;
  logic [PTR_W-1:0]     w_ptr_inc;

  // Reset and clear both mask the grant without waiting for a clock edge.
  assign w_req = (rst_i || clear_i) ? '0 : req_i;

  rr_priority_select #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_sel (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_vld (w_vld)
  );

  always_comb begin
    w_addr = '0;
    for (int k = 0; k < NUM_PORTS; k++)
      if (w_gnt[k]) w_addr = addr_i[k*ADDR_W +: ADDR_W];
  end

  // r_cnt is the position of the previous grant within its burst; r_last is
  // cleared when a burst ends so a repeat grant to that port starts fresh.
  assign w_cont       = (w_gnt == r_last);
  assign w_cnt_nxt    = w_cont ? r_cnt + 1'b1 : '0;
  assign w_burst_more = ({1'b0, w_cnt_nxt} + (CNT_W+1)'(1)) < (CNT_W+1)'(BURST_MAX);
  assign w_ptr_inc    = (w_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_last   <= '0;
      r_rvalid <= '0;
    end else if (clear_i) begin
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_last   <= '0;
      r_rvalid <= '0;
    end else begin
      r_rvalid <= w_gnt;
      if (w_vld) begin
        if (w_burst_more) begin
          r_ptr  <= w_idx;
          r_cnt  <= w_cnt_nxt;
          r_last <= w_gnt;
        end else begin
          r_ptr  <= w_ptr_inc;
          r_cnt  <= '0;
          r_last <= '0;
        end
      end else begin
        r_cnt  <= '0;
        r_last <= '0;
      end
    end
  end

  assign gnt_o      = w_gnt;
  assign mem_en_o   = w_vld;
  assign mem_addr_o = w_addr;
  // A read issued just before a clear is dropped in the clear cycle itself.
  assign rvalid_o   = r_rvalid & {NUM_PORTS{~clear_i}};
  assign rdata_o    = mem_data_i;
  assign busy_o     = (|req_i) | (|rvalid_o);

endmodule
